spi_master: RTL and testbench



---
 rtl/spi_master.sv | 199 +++++++++++++++++++
 tb/tb_spi_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-3 (CPOL=1, CPHA=1) MSB-first master, 1..32 bit frames
//
// Purpose:
//   Runs one SPI transaction per request from the sensor sequencer and
//   returns the shifted-in word, right-aligned and zero-extended.
//   Frame: CS setup, (spi_nbits+1) SCLK periods, CS hold, inter-frame gap.
//   Each phase is CLK_DIV clk_in cycles long.
//
// Parameters:
//   CLK_DIV        SCLK half-period in clk_in cycles (1..255); also sets the
//                  CS setup, CS hold and gap lengths.
//
// Optional build macro:
//   SPI_LOOPBACK_EN  when defined, rx samples the internal mosi value instead
//                    of the miso pin; pin timing is unchanged.
//
// Ports:
//   clk_in         in   1   system clock
//   rst            in   1   synchronous, active-high reset
//   spi_request    in   1   level request, sampled only while idle
//   spi_mosi_data  in   32  transmit word, right-aligned, bit spi_nbits first
//   spi_nbits      in   5   bit count minus one
//   spi_ready      out  1   idle and able to accept a request
//   spi_miso_data  out  32  received word, right-aligned, zero-extended
//   sclk           out  1   SPI clock, idles high
//   cs_n           out  1   chip select, active low
//   mosi           out  1   serial data out
//   miso           in   1   serial data in

module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        spi_request,
  input  logic [31:0] spi_mosi_data,
  input  logic [4:0]  spi_nbits,
  output logic        spi_ready,
  output logic [31:0] spi_miso_data,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SCK_LOW,
    S_SCK_HIGH,
    S_CS_HOLD,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        ready_q, ready_d;
  logic [31:0] miso_data_q, miso_data_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;

  logic        rx_in;
  logic        phase_last;

`ifdef SPI_LOOPBACK_EN
  // mosi_q holds the bit currently on the wire throughout SCK_LOW, so the
  // rising-edge capture sees exactly what was transmitted.
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_in       = mosi_q;
`else
  assign rx_in       = miso;
`endif

  // Every non-idle phase lasts CLK_DIV cycles; the state changes on the
  // edge where the phase counter reaches its last value.
  assign phase_last = (cnt_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = 8'd0;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    ready_d     = ready_q;
    miso_data_d = miso_data_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;

    if (state_q != S_IDLE && !phase_last) begin
      cnt_d = cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (spi_request) begin
          tx_d    = spi_mosi_data;
          bit_d   = spi_nbits;
          rx_d    = 32'd0;
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
          state_d = S_CS_SETUP;
        end
      end

      S_CS_SETUP: begin
        if (phase_last) begin
          sclk_d  = 1'b0;
          mosi_d  = tx_q[bit_q];
          state_d = S_SCK_LOW;
        end
      end

      S_SCK_LOW: begin
        if (phase_last) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[30:0], rx_in};
          state_d = S_SCK_HIGH;
        end
      end

      S_SCK_HIGH: begin
        if (phase_last) begin
          if (bit_q == 5'd0) begin
            state_d = S_CS_HOLD;
          end else begin
            // mosi only moves on the falling SCLK edge, away from capture.
            bit_d   = bit_q - 5'd1;
            sclk_d  = 1'b0;
            mosi_d  = tx_q[bit_q - 5'd1];
            state_d = S_SCK_LOW;
          end
        end
      end

      S_CS_HOLD: begin
        if (phase_last) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (phase_last) begin
          // Result and ready are published together so the result is
          // stable for the whole time ready is high.
          miso_data_d = rx_q;
          ready_d     = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bit_q       <= 5'd0;
      tx_q        <= 32'd0;
      rx_q        <= 32'd0;
      ready_q     <= 1'b1;
      miso_data_q <= 32'd0;
      sclk_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      ready_q     <= ready_d;
      miso_data_q <= miso_data_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
    end
  end

  assign spi_ready     = ready_q;
  assign spi_miso_data = miso_data_q;
  assign sclk          = sclk_q;
  assign cs_n          = cs_n_q;
  assign mosi          = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with a mode-3 slave model
module tb_spi_master;

  localparam int CLK_DIV = 2;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        spi_request = 1'b0;
  logic [31:0] spi_mosi_data = 32'd0;
  logic [4:0]  spi_nbits = 5'd0;
  logic        spi_ready;
  logic [31:0] spi_miso_data;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .spi_request   (spi_request),
    .spi_mosi_data (spi_mosi_data),
    .spi_nbits     (spi_nbits),
    .spi_ready     (spi_ready),
    .spi_miso_data (spi_miso_data),
    .sclk          (sclk),
    .cs_n          (cs_n),
    .mosi          (mosi),
    .miso          (miso)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- mode-3 slave model ----------------
  logic [4:0]  cur_n = 5'd0;
  logic [31:0] cur_resp = 32'd0;
  logic [31:0] s_resp = 32'd0;
  int          s_idx = -1;
  int          edges = 0;
  logic [31:0] mosi_cap = 32'd0;

  always @(negedge cs_n) begin
    s_idx    = int'(cur_n);
    s_resp   = cur_resp;
    edges    = 0;
    mosi_cap = 32'd0;
  end

  always @(negedge sclk) begin
    if (!cs_n && s_idx >= 0) begin
      miso = s_resp[s_idx];
      s_idx--;
    end
  end

  always @(posedge sclk) begin
    if (!cs_n) begin
      edges++;
      mosi_cap = {mosi_cap[30:0], mosi};
    end
  end

  // ---------------- pin-level monitors ----------------
  int          hi_run = 0;
  int          last_gap = 0;
  int          mosi_viol = 0;
  int          data_viol = 0;
  logic        prev_cs = 1'b1;
  logic        prev_mosi = 1'b0;
  logic        prev_ready = 1'b1;
  logic        prev_rst = 1'b1;
  logic [31:0] prev_data = 32'd0;

  always @(negedge clk_in) begin
    if (cs_n) begin
      hi_run++;
    end else begin
      if (prev_cs) last_gap = hi_run;
      hi_run = 0;
    end
    if (!rst && !prev_rst) begin
      if (mosi !== prev_mosi && !cs_n && sclk) mosi_viol++;
      if (spi_miso_data !== prev_data && !(spi_ready && !prev_ready)) data_viol++;
    end
    prev_cs    = cs_n;
    prev_mosi  = mosi;
    prev_ready = spi_ready;
    prev_rst   = rst;
    prev_data  = spi_miso_data;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] mask_of(input logic [4:0] n);
    logic [63:0] m;
    m = (64'd1 << (int'(n) + 1)) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic [31:0] expected_rx(input logic [31:0] tx, input logic [4:0] n,
                                               input logic [31:0] resp);
`ifdef SPI_LOOPBACK_EN
    return tx & mask_of(n);
`else
    return resp & mask_of(n);
`endif
  endfunction

  function automatic int expected_low(input logic [4:0] n);
    return (int'(n) + 1) * 2 * CLK_DIV + 3 * CLK_DIV;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input logic [31:0] tx, input logic [4:0] n, input logic [31:0] resp);
    int guard;
    guard = 0;
    while (spi_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk_in);
      guard++;
    end
    if (guard >= 5000) check_eq("ready_timeout", 32'(spi_ready), 32'd1);
    cur_n         = n;
    cur_resp      = resp;
    spi_mosi_data = tx;
    spi_nbits     = n;
    spi_request   = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic finish_frame(input string tag, input logic [31:0] tx, input logic [4:0] n,
                              input logic [31:0] resp);
    int low;
    low = 0;
    while (spi_ready === 1'b0 && low < 5000) begin
      @(negedge clk_in);
      low++;
    end
    check_eq({tag, "_ready_low"}, 32'(low), 32'(expected_low(n)));
    check_eq({tag, "_rx"}, spi_miso_data, expected_rx(tx, n, resp));
    check_eq({tag, "_edges"}, 32'(edges), 32'(int'(n) + 1));
    check_eq({tag, "_mosi"}, mosi_cap, tx & mask_of(n));
  endtask

  // Request drops right after acceptance and the inputs are scribbled while
  // busy; neither may influence the running frame.
  task automatic run_frame(input string tag, input logic [31:0] tx, input logic [4:0] n,
                           input logic [31:0] resp);
    start_frame(tx, n, resp);
    spi_request   = 1'b0;
    spi_mosi_data = $urandom;
    spi_nbits     = 5'($urandom);
    finish_frame(tag, tx, n, resp);
  endtask

  initial begin
    logic [31:0] rtx, rresp;
    logic [4:0]  rn;

    repeat (3) @(negedge clk_in);
    check_eq("rst_ready", 32'(spi_ready), 32'd1);
    check_eq("rst_cs_n", 32'(cs_n), 32'd1);
    check_eq("rst_sclk", 32'(sclk), 32'd1);
    check_eq("rst_mosi", 32'(mosi), 32'd0);
    check_eq("rst_data", spi_miso_data, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);

    run_frame("whoami", 32'h0000_8F00, 5'd15, 32'h0000_0033);
    run_frame("regwr", 32'h0000_2077, 5'd15, 32'hFFFF_FFFF);
    run_frame("accel", 32'h00E8_0000, 5'd23, 32'h0000_9A01);

    // Reset in the middle of a 24-bit frame.
    start_frame(32'h00E8_0000, 5'd23, 32'h00AB_CDEF);
    repeat (20) @(negedge clk_in);
    spi_request = 1'b0;
    rst = 1'b1;
    @(posedge clk_in);
    #1;
    check_eq("midrst_cs_n", 32'(cs_n), 32'd1);
    check_eq("midrst_sclk", 32'(sclk), 32'd1);
    check_eq("midrst_ready", 32'(spi_ready), 32'd1);
    check_eq("midrst_data", spi_miso_data, 32'd0);
    check_eq("midrst_mosi", 32'(mosi), 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    run_frame("postrst", 32'h00C3_5A96, 5'd23, 32'h0012_3456);

    // Back-to-back with request held high: 1-bit frame then 32-bit frame.
    start_frame(32'h0000_0001, 5'd0, 32'h0000_0001);
    spi_mosi_data = 32'hA5A5_0FF0;
    spi_nbits     = 5'd31;
    cur_n         = 5'd31;
    cur_resp      = 32'hDEAD_BEEF;
    finish_frame("b2b_1bit", 32'h0000_0001, 5'd0, 32'h0000_0001);
    @(negedge clk_in);
    spi_request = 1'b0;
    check_eq("b2b_cs_gap_ok", 32'(last_gap >= CLK_DIV + 1), 32'd1);
    finish_frame("b2b_32bit", 32'hA5A5_0FF0, 5'd31, 32'hDEAD_BEEF);

`ifdef SPI_LOOPBACK_EN
    run_frame("loopback", 32'hFFA5_C33C, 5'd23, 32'h0000_0000);
`endif

    for (int i = 0; i < 8; i++) begin
      rtx   = $urandom;
      rresp = $urandom;
      rn    = 5'($urandom_range(0, 31));
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
      run_frame($sformatf("rand%0d", i), rtx, rn, rresp);
    end

    check_eq("mosi_change_sclk_high", 32'(mosi_viol), 32'd0);
    check_eq("data_unstable", 32'(data_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
